// File: rtl/sh_ocl_req_arb.sv
// Round-robin arbiter that shares one single-beat downstream request port among NUM_REQ requesters.
// Optional watchdog: define SH_ARB_TIMEOUT_EN to enable the ISSUE/WAIT timeout and timeout_flag.
module sh_ocl_req_arb #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk_main_a0,
  input  logic                      rst_main_n,
  input  logic [NUM_REQ-1:0]        req_vld,
  output logic [NUM_REQ-1:0]        req_rdy,
  input  logic [NUM_REQ-1:0]        req_wr,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_vld,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      m_vld,
  input  logic                      m_rdy,
  output logic                      m_wr,
  output logic [ADDR_W-1:0]         m_addr,
  output logic [DATA_W-1:0]         m_wdata,
  input  logic                      m_rsp_vld,
  input  logic [DATA_W-1:0]         m_rsp_rdata,
  input  logic                      m_rsp_err,
  output logic                      busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                      timeout_flag
);

  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [ID_W-1:0] last_grant;
  logic [ID_W-1:0] winner;
  logic            found;
  logic            to_hit;

  // Rotating priority: search starts just after the previous winner.
  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    int idx;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(last_grant) + 1 + k) % NUM_REQ;
      if (!found && req_vld[idx]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

`ifdef SH_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] to_cnt;

  assign to_hit = ((state == S_ISSUE) || (state == S_WAIT)) &&
                  (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_main_a0) begin
    if (!rst_main_n) begin
      to_cnt       <= '0;
      timeout_flag <= 1'b0;
    end else begin
      if (state == S_IDLE)
        to_cnt <= '0;
      else if ((state == S_ISSUE) || (state == S_WAIT))
        to_cnt <= to_cnt + 1'b1;
      // A real response arriving in the timeout cycle wins over the watchdog.
      if (to_hit && !((state == S_WAIT) && m_rsp_vld))
        timeout_flag <= 1'b1;
    end
  end
`else
  assign to_hit       = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (found) state_nxt = S_ISSUE;
      S_ISSUE: begin
        if (to_hit)     state_nxt = S_RESP;
        else if (m_rdy) state_nxt = S_WAIT;
      end
      S_WAIT:  if (m_rsp_vld || to_hit) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk_main_a0) begin
    if (!rst_main_n) begin
      state      <= S_IDLE;
      last_grant <= ID_W'(NUM_REQ - 1);
      grant_id   <= '0;
      m_wr       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state == S_IDLE) && found) begin
        last_grant <= winner;
        grant_id   <= winner;
        m_wr       <= req_wr[winner];
        m_addr     <= req_addr[int'(winner)*ADDR_W +: ADDR_W];
        m_wdata    <= req_wdata[int'(winner)*DATA_W +: DATA_W];
      end
      if ((state == S_WAIT) && m_rsp_vld) begin
        rsp_rdata <= m_rsp_rdata;
        rsp_err   <= m_rsp_err;
      end else if (to_hit) begin
        rsp_rdata <= {(DATA_W/32){32'hDEAD_BEEF}};
        rsp_err   <= 1'b1;
      end
    end
  end

  // Accept is gated by reset so nothing looks accepted while reset is held.
  always_comb begin
    req_rdy = '0;
    if ((state == S_IDLE) && found && rst_main_n)
      req_rdy[winner] = 1'b1;
  end

  always_comb begin
    rsp_vld = '0;
    if (state == S_RESP)
      rsp_vld[grant_id] = 1'b1;
  end

  assign m_vld = (state == S_ISSUE) && !to_hit;
  assign busy  = (state != S_IDLE);

endmodule
